// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl : 4-entry register file + IDLE/RD/EX/WB sequencer feeding a W-bit ALU
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_seq_ctrl #(
  parameter int W    = 4,
  parameter int NREG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [1:0]   rd,
  input  logic [1:0]   rs1,
  input  logic [1:0]   rs2,
  input  logic         wr_en,
  input  logic [1:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [1:0]   rd_addr,
  output logic [W-1:0] rd_data,
  output logic [1:0]   alu_s,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_c,
  input  logic         alu_co,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         flag_c,
  output logic         flag_z,
  output logic         wr_drop
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EX   = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] regs_q [NREG];
  logic [W-1:0] regs_d [NREG];
  logic [1:0]   op_q, op_d, rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [1:0]   alu_s_q, alu_s_d;
  logic [W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [W-1:0] cap_c_q, cap_c_d;
  logic         cap_co_q, cap_co_d;
  logic [W-1:0] result_q, result_d;
  logic         flag_c_q, flag_c_d, flag_z_q, flag_z_d;
  logic         done_q, done_d, wr_drop_q, wr_drop_d;

  always_comb begin
    state_d   = state_q;
    regs_d    = regs_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    alu_s_d   = alu_s_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    cap_c_d   = cap_c_q;
    cap_co_d  = cap_co_q;
    result_d  = result_q;
    flag_c_d  = flag_c_q;
    flag_z_d  = flag_z_q;
    done_d    = (state_q == S_WB);
    wr_drop_d = wr_en && (state_q == S_WB);

    // Write-back owns the register file port in WB; external loads lose.
    if (wr_en && (state_q != S_WB)) begin
      regs_d[wr_addr] = wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          rd_d    = rd;
          rs1_d   = rs1;
          rs2_d   = rs2;
          state_d = S_RD;
        end
      end
      S_RD: begin
        alu_s_d = op_q;
        alu_a_d = regs_q[rs1_q];
        alu_b_d = regs_q[rs2_q];
        state_d = S_EX;
      end
      S_EX: begin
        cap_c_d  = alu_c;
        cap_co_d = alu_co;
        state_d  = S_WB;
      end
      S_WB: begin
        regs_d[rd_q] = cap_c_q;
        result_d     = cap_c_q;
        flag_c_d     = cap_co_q;
        flag_z_d     = (cap_c_q == '0);
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      alu_s_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      cap_c_q   <= '0;
      cap_co_q  <= 1'b0;
      result_q  <= '0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      done_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      regs_q    <= regs_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      alu_s_q   <= alu_s_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      cap_c_q   <= cap_c_d;
      cap_co_q  <= cap_co_d;
      result_q  <= result_d;
      flag_c_q  <= flag_c_d;
      flag_z_q  <= flag_z_d;
      done_q    <= done_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  assign rd_data = regs_q[rd_addr];
  assign alu_s   = alu_s_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign result  = result_q;
  assign flag_c  = flag_c_q;
  assign flag_z  = flag_z_q;
  assign wr_drop = wr_drop_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl : self-checking bench for alu_seq_ctrl with a behavioural ALU
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = '0, rd = '0, rs1 = '0, rs2 = '0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [1:0] rd_addr = '0;
  logic [3:0] rd_data;
  logic [1:0] alu_s;
  logic [3:0] alu_a, alu_b, alu_c;
  logic       alu_co;
  logic       busy, done, flag_c, flag_z, wr_drop;
  logic [3:0] result;
  logic [4:0] alu_res;

  int tests = 0;
  int fails = 0;

  logic [3:0] m_regs [4];

  alu_seq_ctrl #(.W(4), .NREG(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_co(alu_co), .busy(busy), .done(done), .result(result), .flag_c(flag_c),
    .flag_z(flag_z), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  // Downstream 4-bit ALU
  always_comb begin
    case (alu_s)
      2'd0:    alu_res = {1'b0, alu_a} + {1'b0, alu_b};
      2'd1:    alu_res = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
      2'd2:    alu_res = {1'b0, alu_a & alu_b};
      default: alu_res = {1'b0, alu_a | alu_b};
    endcase
  end
  assign alu_c  = alu_res[3:0];
  assign alu_co = alu_res[4];

  // Reference: {carry, value}; sub carry means "no borrow", i.e. a >= b.
  function automatic logic [4:0] ref_op(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
    int ai, bi;
    ai = a;
    bi = b;
    case (o)
      2'd0:    return 5'(ai + bi);
      2'd1:    return {(ai >= bi), 4'((ai - bi + 16) % 16)};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Issues one command and observes it through to the done cycle.
  task automatic run_cmd(input logic [1:0] o, input logic [1:0] d, input logic [1:0] s1, input logic [1:0] s2,
                         input logic wr, input logic [1:0] wa, input logic [3:0] wd,
                         output int early, output logic lat_ok, output logic [1:0] obs_s,
                         output logic [3:0] obs_a, output logic [3:0] obs_b, output logic [3:0] obs_res,
                         output logic obs_c, output logic obs_z, output logic [3:0] obs_rd);
    start = 1'b1; op = o; rd = d; rs1 = s1; rs2 = s2;
    wr_en = wr; wr_addr = wa; wr_data = wd;
    tick();
    start = 1'b0; wr_en = 1'b0;
    op = 2'($urandom); rd = 2'($urandom); rs1 = 2'($urandom); rs2 = 2'($urandom);
    early = done ? 1 : 0;
    tick();
    obs_s = alu_s; obs_a = alu_a; obs_b = alu_b;
    if (done) early++;
    tick();
    if (done) early++;
    tick();
    lat_ok = done && !busy;
    obs_res = result; obs_c = flag_c; obs_z = flag_z;
    rd_addr = d;
    #1;
    obs_rd = rd_data;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      tests++;
      if (rd_data !== 4'd0) begin
        fails++; $display("FAIL reset_reg%0d got %h want 0", i, rd_data);
      end
    end
    tests++;
    if ({result, flag_c, flag_z, alu_s, alu_a, alu_b, done, wr_drop, busy} !== 19'd0) begin
      fails++;
      $display("FAIL reset_outs got res=%h c=%b z=%b s=%h a=%h b=%h done=%b drop=%b busy=%b want all 0",
               result, flag_c, flag_z, alu_s, alu_a, alu_b, done, wr_drop, busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sub;
    int e; logic l, c, z; logic [1:0] s; logic [3:0] a, b, r, v;
    load(2'd1, 4'd5);
    load(2'd2, 4'd3);
    run_cmd(2'd1, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 4'd0, e, l, s, a, b, r, c, z, v);
    tests++;
    if (e != 0 || !l) begin fails++; $display("FAIL sub_latency early=%0d done_at_4=%b want 0/1", e, l); end
    tests++;
    if ({v, r, c, z} !== {4'd2, 4'd2, 1'b1, 1'b0}) begin
      fails++; $display("FAIL sub_5_3 got R0=%h res=%h c=%b z=%b want 2 2 1 0", v, r, c, z);
    end
    run_cmd(2'd1, 2'd0, 2'd2, 2'd1, 1'b0, 2'd0, 4'd0, e, l, s, a, b, r, c, z, v);
    tests++;
    if ({v, r, c, z} !== {4'hE, 4'hE, 1'b0, 1'b0}) begin
      fails++; $display("FAIL sub_3_5 got R0=%h res=%h c=%b z=%b want e e 0 0", v, r, c, z);
    end
  endtask

  task automatic test_logic;
    int e; logic l, c, z; logic [1:0] s; logic [3:0] a, b, r, v;
    load(2'd1, 4'd9);
    load(2'd2, 4'd8);
    run_cmd(2'd0, 2'd3, 2'd1, 2'd2, 1'b0, 2'd0, 4'd0, e, l, s, a, b, r, c, z, v);
    tests++;
    if ({v, c, z} !== {4'd1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL add_9_8 got R3=%h c=%b z=%b want 1 1 0", v, c, z);
    end
    tests++;
    if ({s, a, b} !== {2'd0, 4'd9, 4'd8}) begin
      fails++; $display("FAIL alu_drive got s=%h a=%h b=%h want 0 9 8", s, a, b);
    end
    run_cmd(2'd2, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 4'd0, e, l, s, a, b, r, c, z, v);
    tests++;
    if ({r, c, z} !== {4'd8, 1'b0, 1'b0}) begin
      fails++; $display("FAIL and_9_8 got res=%h c=%b z=%b want 8 0 0", r, c, z);
    end
    run_cmd(2'd3, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 4'd0, e, l, s, a, b, r, c, z, v);
    tests++;
    if ({r, c} !== {4'd9, 1'b0}) begin
      fails++; $display("FAIL or_9_8 got res=%h c=%b want 9 0", r, c);
    end
  endtask

  task automatic test_busy_ignore;
    int pulses;
    pulses = 0;
    start = 1'b1; op = 2'd1; rd = 2'd1; rs1 = 2'd1; rs2 = 2'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      op = 2'd0; rd = 2'd2; rs1 = 2'd3; rs2 = 2'd0;
      if (done) pulses++;
      if (i == 3) start = 1'b0;
    end
    tests++;
    if (pulses != 1) begin fails++; $display("FAIL busy_ignore pulses=%0d want 1", pulses); end
    rd_addr = 2'd1;
    #1;
    tests++;
    if ({rd_data, flag_z, flag_c} !== {4'd0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL sub_self got R1=%h z=%b c=%b want 0 1 1", rd_data, flag_z, flag_c);
    end
    rd_addr = 2'd2;
    #1;
    tests++;
    if (rd_data !== 4'd8) begin fails++; $display("FAIL busy_no_wb R2=%h want 8", rd_data); end
  endtask

  task automatic test_wr_drop;
    start = 1'b1; op = 2'd3; rd = 2'd0; rs1 = 2'd1; rs2 = 2'd2;
    tick(); start = 1'b0;
    tick(); tick();
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'd5;
    tick();
    wr_en = 1'b0;
    rd_addr = 2'd2;
    #1;
    tests++;
    if ({wr_drop, done, rd_data} !== {1'b1, 1'b1, 4'd8}) begin
      fails++; $display("FAIL wr_drop_wb got drop=%b done=%b R2=%h want 1 1 8", wr_drop, done, rd_data);
    end
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'd5;
    tick();
    wr_en = 1'b0;
    tests++;
    if ({wr_drop, rd_data} !== {1'b0, 4'd5}) begin
      fails++; $display("FAIL wr_in_ex got drop=%b R2=%h want 0 5", wr_drop, rd_data);
    end
    tick();
    tests++;
    if ({done, result} !== {1'b1, 4'd8}) begin
      fails++; $display("FAIL wr_in_ex_res got done=%b res=%h want 1 8", done, result);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulses = 0;
    start = 1'b1; op = 2'd0; rd = 2'd3; rs1 = 2'd2; rs2 = 2'd0;
    tick(); start = 1'b0;
    tick();
    rd_addr = 2'd2;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, alu_a, alu_b, result, flag_c, rd_data} !== 15'd0) begin
      fails++; $display("FAIL reset_async got busy=%b done=%b a=%h b=%h res=%h c=%b R2=%h want all 0",
                        busy, done, alu_a, alu_b, result, flag_c, rd_data);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) pulses++;
    end
    tests++;
    if (pulses != 0) begin fails++; $display("FAIL reset_abort pulses=%0d want 0", pulses); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      tests++;
      if (rd_data !== 4'd0) begin fails++; $display("FAIL reset_mid_reg%0d got %h want 0", i, rd_data); end
    end
  endtask

  task automatic test_random;
    int e; logic l, c, z, wr; logic [1:0] s, o, d, s1, s2, wa; logic [3:0] a, b, r, v, wd;
    logic [4:0] exp;
    for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        wa = 2'($urandom); wd = 4'($urandom);
        load(wa, wd);
        m_regs[wa] = wd;
      end
      o = 2'($urandom); d = 2'($urandom); s1 = 2'($urandom); s2 = 2'($urandom);
      wr = 1'($urandom); wa = 2'($urandom); wd = 4'($urandom);
      if (n % 5 == 0) begin s1 = d; s2 = d; end
      run_cmd(o, d, s1, s2, wr, wa, wd, e, l, s, a, b, r, c, z, v);
      if (wr) m_regs[wa] = wd;
      exp = ref_op(o, m_regs[s1], m_regs[s2]);
      tests++;
      if (e != 0 || !l || {s, a, b} !== {o, m_regs[s1], m_regs[s2]}) begin
        fails++; $display("FAIL rand%0d_issue early=%0d lat=%b s=%h a=%h b=%h want 0 1 %h %h %h",
                          n, e, l, s, a, b, o, m_regs[s1], m_regs[s2]);
      end
      tests++;
      if ({v, r, c, z} !== {exp[3:0], exp[3:0], exp[4], exp[3:0] == 4'd0}) begin
        fails++; $display("FAIL rand%0d_wb got Rd=%h res=%h c=%b z=%b want %h %h %b %b",
                          n, v, r, c, z, exp[3:0], exp[3:0], exp[4], exp[3:0] == 4'd0);
      end
      m_regs[d] = exp[3:0];
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      tests++;
      if (rd_data !== m_regs[i]) begin fails++; $display("FAIL rand_reg%0d got %h want %h", i, rd_data, m_regs[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_logic();
    test_busy_ignore();
    test_wr_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencing stage that sits directly upstream of the 4-bit ALU. It holds a 4-entry register file, issues one ALU operation per command through a start/busy/done handshake, and drives the ALU's op-select and operand inputs. It then captures the ALU result and carry-out, writes the result back to a destination register, and keeps carry and zero flags.

Parameters:
W, 4, data width; must match the ALU width.
NREG, 4, number of registers; fixed at 4, so register addresses are 2 bits.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
start  in  1  command strobe; sampled only in IDLE.
op  in  2  operation: 00 add, 01 sub, 10 and, 11 or.
rd  in  2  destination register address.
rs1  in  2  source register address for operand A.
rs2  in  2  source register address for operand B.
wr_en  in  1  external register-load strobe.
wr_addr  in  2  external load address.
wr_data  in  W  external load data.
rd_addr  in  2  debug read address.
rd_data  out  W  combinational read of regs[rd_addr].
alu_s  out  2  ALU op select (the ALU's S input).
alu_a  out  W  ALU operand A.
alu_b  out  W  ALU operand B.
alu_c  in  W  ALU result.
alu_co  in  1  ALU carry-out.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when write-back completes.
result  out  W  last written-back value.
flag_c  out  1  carry flag.
flag_z  out  1  zero flag.
wr_drop  out  1  one-cycle pulse when an external write is discarded.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - regs[0..3], result, flag_c, flag_z, alu_s, alu_a, alu_b, done and wr_drop all go to 0.
- FSM is IDLE -> RD -> EX -> WB -> IDLE, with exactly one cycle in each non-IDLE state.
- IDLE:
  - If start=1 on an edge, latch op, rd, rs1 and rs2 into command registers and go to RD.
  - Otherwise stay in IDLE.
- RD:
  - Load alu_a <= regs[rs1], alu_b <= regs[rs2], alu_s <= op.
  - alu_s, alu_a and alu_b are registered outputs and hold their value until the next RD.
- EX:
  - ALU inputs are stable for the full cycle.
  - On the edge leaving EX, capture alu_c and alu_co into internal holding registers.
- WB, on the edge leaving WB:
  - regs[rd] <= captured value and result <= captured value.
  - flag_c <= captured carry for every op, so it is 0 for and/or.
  - flag_z <= (captured value == 0).
  - done=1 for the WB->IDLE cycle only.
- Latency: start sampled at edge n gives done high in the cycle after edge n+3. Updated regs[rd], result and flags are visible in that same cycle.
- Throughput: one command per 4 cycles. A new start is accepted in the cycle done is high, because the state is already IDLE.
- start while busy=1 is ignored; it is neither queued nor flagged.
- Command fields are latched at start, so changes on op/rd/rs1/rs2 while busy have no effect.
- Sub semantics are A + ~B + 1, computed by the ALU. flag_c=1 means no borrow.
- Add carry is the unsigned overflow out of bit W-1.
- External writes:
  - With wr_en=1 in any state except WB, regs[wr_addr] <= wr_data on the edge.
  - With wr_en=1 in WB, write-back has priority: the external write is dropped and wr_drop pulses for 1 cycle.
- Operand sampling: an external write to rs1/rs2 on the same edge that leaves IDLE is seen by RD, because RD reads the register file on the following edge.
- rs1 == rs2 == rd is legal; operands are read in RD, before the write-back.
- rd_data is a combinational read that reflects regs after the most recent edge.
- Reset mid-command aborts it: no write-back and no done pulse.

Test Plan:
- Reset, then load R1=5 and R2=3; issue sub rd=0, rs1=1, rs2=2 -> done exactly 4 cycles after start; R0=2, flag_c=1, flag_z=0.
- Sub rs1=2, rs2=1 (3-5) -> result=0xE, flag_c=0 (borrow), flag_z=0.
- Load R1=9 and R2=8; add rd=3 -> R3=1, flag_c=1. Then and R1,R2 -> result=8, flag_c=0. Then or R1,R2 -> 9.
- Sub R1,R1 with rd=1 -> R1=0, flag_z=1, flag_c=1. Assert start again while busy -> ignored, exactly one done pulse.
- External wr_en to R2 during the WB cycle -> wr_drop pulses and R2 is unchanged. The same write during EX -> R2 is updated.
- Assert rst_n=0 during EX -> outputs 0 immediately (asynchronous), no done pulse, all regs=0 after release.
